nes_controller_emulator: RTL and testbench

//  Responder end of the NES controller serial link: emulates a 4021-based pad for the pong datapath.

---
 rtl/nes_controller_emulator.sv | 188 ++++++++++++++++++
 tb/tb_nes_controller_emulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_emulator.sv
// Responder side of the NES pad serial link. It emulates a 4021 shift register and presents
// 8 active-low button bits on nes_data, clocked by the initiator's latch/clk pins.
//
// state | meaning
// IDLE  | waiting for latch rise, line parked high
// LOAD  | latch high, live parallel load of A, counting latch width
// SHIFT | shifting B..Right out on synchronized clk rises
// TAIL  | all 8 bits presented, extra clocks read TAIL_LEVEL
module nes_controller_emulator #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   MIN_LATCH_CYC = 64,
    parameter int   TIMEOUT_CYC   = 4096,
    parameter logic TAIL_LEVEL    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  buttons,
    input  logic        nes_latch,
    input  logic        nes_clk,
    output logic        nes_data,
    output logic        frame_done,
    output logic        latch_glitch,
    output logic        frame_abort,
    output logic [15:0] frame_cnt,
    output logic        busy
);
    localparam int LCW = $clog2(MIN_LATCH_CYC + 1);
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LCW-1:0] MIN_L     = LCW'(MIN_LATCH_CYC);
    localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_TAIL} state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst;
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign rst        = rst_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= rst_sync_d;
    end

    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d, clk_sync_q, clk_sync_d;
    logic latch_prev_q, latch_prev_d, clk_prev_q, clk_prev_d;
    logic latch_rise, latch_fall, clk_rise;

    assign latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], nes_latch};
    assign clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], nes_clk};
    assign latch_prev_d = latch_sync_q[SYNC_STAGES-1];
    assign clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
    assign latch_rise   =  latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;
    assign latch_fall   = ~latch_sync_q[SYNC_STAGES-1] &  latch_prev_q;
    assign clk_rise     =  clk_sync_q[SYNC_STAGES-1]   & ~clk_prev_q;

    state_t          state_q, state_d;
    logic [LCW-1:0]  latch_cnt_q, latch_cnt_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d, shift_idx;
    logic [7:0]      snapshot_q, snapshot_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            nes_data_q, nes_data_d;
    logic            frame_done_q, frame_done_d;
    logic            glitch_q, glitch_d;
    logic            abort_q, abort_d;
    logic            busy_q, busy_d;

    assign shift_idx = 3'd6 - bit_cnt_q;

    always_comb begin
        state_d      = state_q;
        latch_cnt_d  = latch_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        snapshot_d   = snapshot_q;
        frame_cnt_d  = frame_cnt_q;
        nes_data_d   = nes_data_q;
        frame_done_d = 1'b0;
        glitch_d     = 1'b0;
        abort_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                nes_data_d = 1'b1;
                if (latch_rise) begin
                    state_d     = ST_LOAD;
                    latch_cnt_d = LCW'(1);
                    nes_data_d  = ~buttons[7];
                end
            end
            ST_LOAD: begin
                nes_data_d = ~buttons[7];
                if (latch_fall) begin
                    if (latch_cnt_q >= MIN_L) begin
                        snapshot_d = buttons;
                        bit_cnt_d  = 3'd0;
                        wait_cnt_d = '0;
                        state_d    = ST_SHIFT;
                    end else begin
                        glitch_d   = 1'b1;
                        nes_data_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (latch_cnt_q != MIN_L) begin
                    latch_cnt_d = latch_cnt_q + LCW'(1);
                end
            end
            ST_SHIFT: begin
                // Latch restart has priority over a coincident clock edge.
                if (latch_rise) begin
                    abort_d     = 1'b1;
                    state_d     = ST_LOAD;
                    latch_cnt_d = LCW'(1);
                    nes_data_d  = ~buttons[7];
                end else if (clk_rise) begin
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    nes_data_d = ~snapshot_q[shift_idx];
                    wait_cnt_d = '0;
                    if (bit_cnt_q == 3'd6) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        state_d      = ST_TAIL;
                    end
                end else if (wait_cnt_q == TIMEOUT_W) begin
                    abort_d    = 1'b1;
                    nes_data_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            default: begin
                // Right stays on the line until the initiator clocks past it.
                if (latch_rise) begin
                    state_d     = ST_LOAD;
                    latch_cnt_d = LCW'(1);
                    nes_data_d  = ~buttons[7];
                end else if (clk_rise) begin
                    nes_data_d = TAIL_LEVEL;
                end
            end
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b0;
            state_q      <= ST_IDLE;
            latch_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            bit_cnt_q    <= 3'd0;
            snapshot_q   <= 8'd0;
            frame_cnt_q  <= 16'd0;
            nes_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
            glitch_q     <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            latch_sync_q <= latch_sync_d;
            clk_sync_q   <= clk_sync_d;
            latch_prev_q <= latch_prev_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            latch_cnt_q  <= latch_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            snapshot_q   <= snapshot_d;
            frame_cnt_q  <= frame_cnt_d;
            nes_data_q   <= nes_data_d;
            frame_done_q <= frame_done_d;
            glitch_q     <= glitch_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
        end
    end

    assign nes_data     = nes_data_q;
    assign frame_done   = frame_done_q;
    assign latch_glitch = glitch_q;
    assign frame_abort  = abort_q;
    assign frame_cnt    = frame_cnt_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_nes_controller_emulator.sv
// Directed bench for nes_controller_emulator: vector table of full frames plus
// hand-written restart, timeout, snapshot and async-reset sequences.
module tb_nes_controller_emulator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  buttons = 8'h00;
    logic        nes_latch = 1'b0;
    logic        nes_clk = 1'b0;
    logic        nes_data, frame_done, latch_glitch, frame_abort, busy;
    logic [15:0] frame_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int done_cnt = 0, glitch_cnt = 0, abort_cnt = 0;
    int exp_frames = 0;

    nes_controller_emulator dut (
        .clk(clk), .reset(reset), .buttons(buttons),
        .nes_latch(nes_latch), .nes_clk(nes_clk), .nes_data(nes_data),
        .frame_done(frame_done), .latch_glitch(latch_glitch),
        .frame_abort(frame_abort), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)   done_cnt   <= done_cnt + 1;
        if (latch_glitch) glitch_cnt <= glitch_cnt + 1;
        if (frame_abort)  abort_cnt  <= abort_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] btn;
        int         latch_len;
        logic       valid;
        logic [7:0] exp_seq;   // [7] is the first bit on the line (A)
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_pulse(input int n);
        nes_latch = 1'b1;
        tick(n);
        nes_latch = 1'b0;
        tick(6);
    endtask

    task automatic clk_pulse();
        nes_clk = 1'b1;
        tick(6);
        nes_clk = 1'b0;
        tick(6);
    endtask

    initial begin
        int d0, g0, a0, f0;
        logic [7:0] seq;
        vecs[0] = '{8'b1001_0100, 152, 1'b1, 8'b0110_1011};
        vecs[1] = '{8'h00,         64, 1'b1, 8'hFF};
        vecs[2] = '{8'hFF,         63, 1'b0, 8'h00};
        vecs[3] = '{8'hA5,        100, 1'b1, 8'h5A};
        vecs[4] = '{8'h81,         20, 1'b0, 8'h7E};
        vecs[5] = '{8'h01,         70, 1'b1, 8'hFE};

        tick(3);
        chk("reset_data", {31'd0, nes_data}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("reset_pulses", {29'd0, frame_done, latch_glitch, frame_abort}, 32'd0);
        reset = 1'b0;
        tick(5);

        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt; g0 = glitch_cnt;
            buttons = vecs[v].btn;
            seq = vecs[v].exp_seq;
            nes_latch = 1'b1;
            tick(10);
            chk($sformatf("v%0d_live_a", v), {31'd0, nes_data}, {31'd0, seq[7]});
            chk($sformatf("v%0d_busy_load", v), {31'd0, busy}, 32'd1);
            tick(vecs[v].latch_len - 10);
            nes_latch = 1'b0;
            tick(6);
            if (vecs[v].valid) begin
                chk($sformatf("v%0d_bit0", v), {31'd0, nes_data}, {31'd0, seq[7]});
                for (int i = 1; i < 8; i++) begin
                    clk_pulse();
                    chk($sformatf("v%0d_bit%0d", v, i), {31'd0, nes_data}, {31'd0, seq[7-i]});
                end
                exp_frames++;
                chk($sformatf("v%0d_done", v), done_cnt - d0, 32'd1);
                chk($sformatf("v%0d_fcnt", v), {16'd0, frame_cnt}, exp_frames);
                clk_pulse();
                chk($sformatf("v%0d_tail", v), {31'd0, nes_data}, 32'd0);
                chk($sformatf("v%0d_busy_tail", v), {31'd0, busy}, 32'd0);
            end else begin
                chk($sformatf("v%0d_glitch", v), glitch_cnt - g0, 32'd1);
                chk($sformatf("v%0d_idle_data", v), {31'd0, nes_data}, 32'd1);
                chk($sformatf("v%0d_idle_busy", v), {31'd0, busy}, 32'd0);
                chk($sformatf("v%0d_fcnt", v), {16'd0, frame_cnt}, exp_frames);
            end
        end

        // Mid-frame latch restart
        buttons = 8'b1001_0100;
        a0 = abort_cnt; d0 = done_cnt;
        latch_pulse(80);
        repeat (3) clk_pulse();
        chk("restart_start_bit", {31'd0, nes_data}, 32'd0);
        buttons = 8'b0001_0100;
        latch_pulse(80);
        chk("restart_abort", abort_cnt - a0, 32'd1);
        chk("restart_a_bit", {31'd0, nes_data}, 32'd1);
        chk("restart_fcnt", {16'd0, frame_cnt}, exp_frames);
        repeat (7) clk_pulse();
        exp_frames++;
        chk("restart_done", done_cnt - d0, 32'd1);
        chk("restart_fcnt2", {16'd0, frame_cnt}, exp_frames);

        // Timeout while waiting for a clock edge
        buttons = 8'hFF;
        a0 = abort_cnt;
        latch_pulse(80);
        repeat (2) clk_pulse();
        chk("to_mid_data", {31'd0, nes_data}, 32'd0);
        tick(4000);
        chk("to_not_early", abort_cnt - a0, 32'd0);
        begin
            int budget = 400;
            while (abort_cnt == a0 && budget > 0) begin
                tick(1);
                budget--;
            end
        end
        tick(2);
        chk("to_abort", abort_cnt - a0, 32'd1);
        chk("to_data", {31'd0, nes_data}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_fcnt", {16'd0, frame_cnt}, exp_frames);

        // Buttons change after validated latch fall: snapshot wins
        buttons = 8'h00;
        latch_pulse(80);
        buttons = 8'hFF;
        f0 = 0;
        if (nes_data !== 1'b1) f0++;
        for (int i = 1; i < 8; i++) begin
            clk_pulse();
            if (nes_data !== 1'b1) f0++;
        end
        exp_frames++;
        chk("snap_bits_low", f0, 32'd0);
        chk("snap_fcnt", {16'd0, frame_cnt}, exp_frames);

        // Async reset mid-SHIFT, then an over-clocked frame
        buttons = 8'b1001_0100;
        latch_pulse(80);
        repeat (3) clk_pulse();
        chk("ar_pre_busy", {31'd0, busy}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("ar_data", {31'd0, nes_data}, 32'd1);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_fcnt", {16'd0, frame_cnt}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(5);
        latch_pulse(80);
        chk("ar_a_bit", {31'd0, nes_data}, 32'd0);
        repeat (7) clk_pulse();
        chk("ar_right_bit", {31'd0, nes_data}, 32'd1);
        chk("ar_fcnt2", {16'd0, frame_cnt}, 32'd1);
        repeat (4) clk_pulse();
        chk("ar_11th_tail", {31'd0, nes_data}, 32'd0);
        chk("ar_fcnt3", {16'd0, frame_cnt}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
